cam_lvds_align_ctrl: RTL and testbench

- Sequences one camera LVDS deserializer (5 lanes x 8 bits: 4 data lanes plus 1 sync lane, 40-bit parallel word).
- Pulses the deserializer PLL reset, waits for lock, then word-aligns every lane by issuing bitslip pulses until each lane shows its training pattern.
- Runs in the deserializer core-clock domain.
- One instance per camera; start/status bits map to host PIO bits.

---
 rtl/cam_pkg.sv | 30 +++
 rtl/cam_lane_match.sv | 44 ++++
 rtl/cam_lvds_align_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_cam_lvds_align_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types, defaults and helpers for the camera LVDS alignment controller.
package cam_pkg;

  localparam int unsigned DES_FACTOR = 8;
  localparam int unsigned DEF_NUM_LANES = 5;
  localparam logic [DES_FACTOR-1:0] DEF_DATA_PATTERN = 8'h3A;
  localparam logic [DES_FACTOR-1:0] DEF_SYNC_PATTERN = 8'hE9;

  // Lane-slice helper works on a fixed-width bus; callers zero-extend their rxd.
  localparam int unsigned MAX_LANES = 16;
  localparam int unsigned MAX_BUS_W = MAX_LANES * DES_FACTOR;

  typedef enum logic [3:0] {
    StIdle,
    StPllRst,
    StWaitLock,
    StSettle,
    StCheck,
    StSlip,
    StDone,
    StRetry,
    StFail
  } state_e;

  function automatic logic [DES_FACTOR-1:0] lane_word(input logic [MAX_BUS_W-1:0] bus,
                                                      input int unsigned lane);
    return DES_FACTOR'(bus >> (DES_FACTOR * lane));
  endfunction

endpackage

// File: rtl/cam_lane_match.sv
// Per-lane training-word comparator with a saturating consecutive-match counter.
module cam_lane_match
  import cam_pkg::*;
#(
  parameter int unsigned MATCH_COUNT = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  enable_i,
  input  logic [DES_FACTOR-1:0] word_i,
  input  logic [DES_FACTOR-1:0] pattern_i,
  output logic                  hit_o
);

  localparam int unsigned CntW = $clog2(MATCH_COUNT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MATCH_COUNT);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      if (word_i != pattern_i) begin
        cnt_d = '0;
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == CntMax);

endmodule

// File: rtl/cam_lvds_align_ctrl.sv
// Camera LVDS deserializer bring-up: PLL reset, lock wait, and per-lane bitslip word alignment.
module cam_lvds_align_ctrl
  import cam_pkg::*;
#(
  parameter int unsigned           NUM_LANES    = DEF_NUM_LANES,
  parameter logic [DES_FACTOR-1:0] DATA_PATTERN = DEF_DATA_PATTERN,
  parameter logic [DES_FACTOR-1:0] SYNC_PATTERN = DEF_SYNC_PATTERN,
  parameter int unsigned           RST_CYCLES   = 16,
  parameter int unsigned           LOCK_TIMEOUT = 4096,
  parameter int unsigned           SLIP_LATENCY = 4,
  parameter int unsigned           MATCH_COUNT  = 8,
  parameter int unsigned           MAX_RETRY    = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             pll_locked,
  input  logic [NUM_LANES*DES_FACTOR-1:0]  rxd,
  output logic                             pll_areset,
  output logic [NUM_LANES-1:0]             bitslip,
  output logic [NUM_LANES-1:0]             lane_aligned,
  output logic                             aligned,
  output logic                             busy,
  output logic                             fail,
  output logic [NUM_LANES*4-1:0]           slip_cnt
);

  localparam int unsigned TimerW = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);
  // Slip counters must reach 2*DES_FACTOR, one more than the 4-bit diagnostic can show.
  localparam int unsigned SlipW = $clog2(2 * DES_FACTOR + 1);
  localparam logic [SlipW-1:0] SlipLimit = SlipW'(2 * DES_FACTOR);

  state_e                          state_q, state_d;
  logic [TimerW-1:0]               timer_q, timer_d;
  logic [RetryW-1:0]               retry_q, retry_d;
  logic                            fail_q, fail_d;
  logic [NUM_LANES-1:0]            lane_aligned_q, lane_aligned_d;
  logic [NUM_LANES-1:0][SlipW-1:0] slips_q, slips_d;
  logic                            lock_m_q, lock_s_q;
  logic [NUM_LANES-1:0]            hit;
  logic [NUM_LANES-1:0]            slip_pulse;
  logic                            slip_limit;
  logic [MAX_BUS_W-1:0]            rxd_pad;

  assign rxd_pad = MAX_BUS_W'(rxd);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    cam_lane_match #(
      .MATCH_COUNT(MATCH_COUNT)
    ) u_match (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .clear_i  (state_q == StSettle),
      .enable_i (state_q == StCheck),
      .word_i   (lane_word(rxd_pad, g)),
      .pattern_i((g == NUM_LANES - 1) ? SYNC_PATTERN : DATA_PATTERN),
      .hit_o    (hit[g])
    );
  end

  always_comb begin
    slip_limit = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (slips_q[i] == SlipLimit) slip_limit = 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q + 1'b1;
    retry_d        = retry_q;
    fail_d         = fail_q;
    lane_aligned_d = lane_aligned_q;
    slips_d        = slips_q;
    slip_pulse     = '0;

    unique case (state_q)
      StIdle, StFail: begin
        if (start) begin
          state_d = StPllRst;
          retry_d = '0;
          fail_d  = 1'b0;
        end
      end
      StPllRst: begin
        if (timer_q == TimerW'(RST_CYCLES - 1)) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (lock_s_q) begin
          state_d = StSettle;
        end else if (timer_q == TimerW'(LOCK_TIMEOUT - 1)) begin
          state_d = StRetry;
        end
      end
      StSettle: begin
        if (!lock_s_q) begin
          state_d = StRetry;
        end else if (timer_q == TimerW'(SLIP_LATENCY - 1)) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (!lock_s_q) begin
          state_d = StRetry;
        end else begin
          lane_aligned_d = lane_aligned_q | hit;
          if (timer_q == TimerW'(MATCH_COUNT)) begin
            state_d = (&lane_aligned_d) ? StDone : StSlip;
          end
        end
      end
      StSlip: begin
        // Lock loss and the slip limit both suppress the pulse.
        if (!lock_s_q) begin
          state_d = StRetry;
        end else if (slip_limit) begin
          state_d = StFail;
        end else begin
          slip_pulse = ~lane_aligned_q;
          for (int i = 0; i < NUM_LANES; i++) begin
            if (slip_pulse[i]) slips_d[i] = slips_q[i] + 1'b1;
          end
          state_d = StSettle;
        end
      end
      StDone: begin
        if (!lock_s_q) begin
          state_d = StRetry;
        end else if (start) begin
          state_d = StPllRst;
          retry_d = '0;
        end
      end
      StRetry: begin
        if (retry_q == RetryW'(MAX_RETRY)) begin
          state_d = StFail;
        end else begin
          retry_d = retry_q + 1'b1;
          state_d = StPllRst;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StFail && state_q != StFail) fail_d = 1'b1;
    if (state_d == StPllRst && state_q != StPllRst) begin
      lane_aligned_d = '0;
      slips_d        = '0;
    end
    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      timer_q        <= '0;
      retry_q        <= '0;
      fail_q         <= 1'b0;
      lane_aligned_q <= '0;
      slips_q        <= '0;
      lock_m_q       <= 1'b0;
      lock_s_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      retry_q        <= retry_d;
      fail_q         <= fail_d;
      lane_aligned_q <= lane_aligned_d;
      slips_q        <= slips_d;
      lock_m_q       <= pll_locked;
      lock_s_q       <= lock_m_q;
    end
  end

  always_comb begin
    slip_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      slip_cnt[4*i +: 4] = (slips_q[i] > SlipW'(15)) ? 4'hF : 4'(slips_q[i]);
    end
  end

  assign pll_areset   = (state_q == StIdle) || (state_q == StPllRst) || (state_q == StFail);
  assign busy         = !((state_q == StIdle) || (state_q == StDone) || (state_q == StFail));
  assign aligned      = (state_q == StDone);
  assign fail         = fail_q;
  assign lane_aligned = lane_aligned_q;
  assign bitslip      = slip_pulse;

endmodule

// File: tb/tb_cam_lvds_align_ctrl.sv
// Scoreboard bench: a deserializer/PLL model drives the controller; each sequence's outcome
// is predicted from offsets/lock behaviour and checked when busy drops.
module tb_cam_lvds_align_ctrl;
  localparam int NL = 5;
  localparam int DES = 8;
  localparam int RST_W = 16;
  localparam int MAX_RETRY = 3;
  localparam int MIN_GAP = 4 + 8 + 2;

  typedef struct packed {
    logic                aligned;
    logic                fail;
    logic [NL-1:0]       lane_al;
    logic [4*NL-1:0]     slip_cnt;
    logic [NL-1:0][7:0]  pulses;
    logic [7:0]          rst_pulses;
  } exp_t;

  logic clk, rst_n, start, pll_locked;
  logic [NL*DES-1:0] rxd;
  logic pll_areset, aligned, busy, fail;
  logic [NL-1:0] bitslip, lane_aligned;
  logic [NL*4-1:0] slip_cnt;

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;
  exp_t exp_q[$];

  // Stimulus-owned deserializer/PLL settings.
  int init_off[NL];
  logic [NL-1:0] dead;
  bit lock_en, drop_active;
  int lock_delay;
  // Model-owned.
  int slips_seen[NL];

  cam_lvds_align_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pll_locked  (pll_locked),
    .rxd         (rxd),
    .pll_areset  (pll_areset),
    .bitslip     (bitslip),
    .lane_aligned(lane_aligned),
    .aligned     (aligned),
    .busy        (busy),
    .fail        (fail),
    .slip_cnt    (slip_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] pat(input int lane);
    return (lane == NL - 1) ? 8'hE9 : 8'h3A;
  endfunction

  // Outcome from the rules: a lane offset by k needs k slips; a dead lane is slipped until
  // 2*DES slips are used, then the sequence fails; no lock means 1+MAX_RETRY PLL resets.
  function automatic exp_t predict(input int w[NL], input logic [NL-1:0] dd, input bit lock_ok);
    exp_t e;
    int n;
    e = '0;
    if (!lock_ok) begin
      e.fail = 1'b1;
      e.rst_pulses = 8'(MAX_RETRY + 1);
      return e;
    end
    e.rst_pulses = 8'd1;
    for (int i = 0; i < NL; i++) begin
      n = dd[i] ? 2 * DES : w[i];
      e.pulses[i] = 8'(n);
      e.slip_cnt[4*i +: 4] = 4'((n > 15) ? 15 : n);
      e.lane_al[i] = !dd[i];
    end
    e.fail = |dd;
    e.aligned = !e.fail;
    return e;
  endfunction

  initial begin : des_model
    int cnt;
    int off;
    cnt = 0;
    pll_locked = 1'b0;
    rxd = '0;
    for (int i = 0; i < NL; i++) slips_seen[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NL; i++) if (bitslip[i]) slips_seen[i]++;
      if (pll_areset || !lock_en || drop_active) begin
        cnt = 0;
        pll_locked = 1'b0;
      end else if (cnt >= lock_delay) begin
        pll_locked = 1'b1;
      end else begin
        cnt++;
      end
      for (int i = 0; i < NL; i++) begin
        off = (((init_off[i] - slips_seen[i]) % DES) + DES) % DES;
        rxd[DES*i +: DES] = dead[i] ? 8'h00 : rotl(pat(i), off);
      end
    end
  end

  initial begin : monitor
    bit prev_busy, seen;
    int width, rst_pulses, gap;
    int pulses[NL];
    exp_t e;
    prev_busy = 0; seen = 0; width = 0; rst_pulses = 0; gap = 0;
    for (int i = 0; i < NL; i++) pulses[i] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 0;
        continue;
      end
      if (busy && !prev_busy) begin
        seen = 0; width = 0; rst_pulses = 0; gap = 0;
        for (int i = 0; i < NL; i++) pulses[i] = 0;
      end
      if (busy) begin
        if (pll_areset) begin
          width++;
        end else if (width > 0) begin
          check("pll_rst_width", 64'(width), 64'(RST_W));
          rst_pulses++;
          width = 0;
        end
        if (|bitslip) begin
          if (seen) check("bitslip_gap_ok", 64'(gap >= MIN_GAP), 64'(1));
          seen = 1;
          gap = 0;
          for (int i = 0; i < NL; i++) pulses[i] += int'(bitslip[i]);
        end
        gap++;
      end
      if (!busy && prev_busy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("aligned", 64'(aligned), 64'(e.aligned));
          check("fail", 64'(fail), 64'(e.fail));
          check("pll_areset_end", 64'(pll_areset), 64'(e.fail));
          check("lane_aligned", 64'(lane_aligned), 64'(e.lane_al));
          check("slip_cnt", 64'(slip_cnt), 64'(e.slip_cnt));
          check("pll_rst_pulses", 64'(rst_pulses), 64'(e.rst_pulses));
          for (int i = 0; i < NL; i++)
            check($sformatf("bitslips_lane%0d", i), 64'(pulses[i]), 64'(e.pulses[i]));
        end
        done_cnt++;
      end
      prev_busy = busy;
    end
  end

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("sequence_completed", 64'(done_cnt >= target), 64'(1));
  endtask

  task automatic set_lanes(input int w[NL], input logic [NL-1:0] dd, input bit lock_ok,
                           input int delay);
    for (int i = 0; i < NL; i++) init_off[i] = w[i] + slips_seen[i];
    dead = dd;
    lock_en = lock_ok;
    lock_delay = delay;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run(input int w[NL], input logic [NL-1:0] dd, input bit lock_ok,
                     input int delay, input bit poke, input int budget);
    int target;
    @(negedge clk);
    #1;
    set_lanes(w, dd, lock_ok, delay);
    exp_q.push_back(predict(w, dd, lock_ok));
    target = done_cnt + 1;
    pulse_start();
    if (poke) begin
      repeat (18) @(negedge clk);
      check("busy_at_poke", 64'(busy), 64'(1));
      #1;
      pulse_start();
    end
    wait_done(target, budget);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pll_areset"}, 64'(pll_areset), 64'(1));
    check({tag, "_bitslip"}, 64'(bitslip), 64'(0));
    check({tag, "_lane_aligned"}, 64'(lane_aligned), 64'(0));
    check({tag, "_aligned"}, 64'(aligned), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_fail"}, 64'(fail), 64'(0));
    check({tag, "_slip_cnt"}, 64'(slip_cnt), 64'(0));
  endtask

  initial begin : stim
    int w[NL];
    int n, target;
    rst_n = 1'b0;
    start = 1'b0;
    lock_en = 1'b1;
    drop_active = 1'b0;
    lock_delay = 10;
    dead = '0;
    for (int i = 0; i < NL; i++) init_off[i] = 0;

    repeat (3) @(negedge clk);
    check_reset_values("por");
    #1 rst_n = 1'b1;

    // All lanes already on pattern, lock 50 cycles after PLL reset release.
    for (int i = 0; i < NL; i++) w[i] = 0;
    run(w, '0, 1'b1, 50, 1'b0, 2000);

    // Lane 2 rotated by three bits.
    w[2] = 3;
    run(w, '0, 1'b1, 20, 1'b0, 2000);

    // Random offsets and lock delays; the first also pokes start while busy.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NL; i++) w[i] = int'($urandom_range(7, 0));
      run(w, '0, 1'b1, int'($urandom_range(100, 1)), (r == 0), 3000);
    end

    // Lane 0 never shows its pattern.
    for (int i = 0; i < NL; i++) w[i] = int'($urandom_range(7, 0));
    run(w, 5'b00001, 1'b1, 15, 1'b0, 4000);

    // PLL never locks.
    for (int i = 0; i < NL; i++) w[i] = 0;
    run(w, '0, 1'b0, 10, 1'b0, 20000);

    // Aligned, then lose lock for 10 cycles.
    run(w, '0, 1'b1, 20, 1'b0, 2000);
    exp_q.push_back(predict(w, '0, 1'b1));
    target = done_cnt + 1;
    @(negedge clk);
    #1 drop_active = 1'b1;
    n = 0;
    while (pll_locked && n < 5) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (aligned && n < 6) begin
      @(negedge clk);
      n++;
    end
    check("aligned_fall_within_3", 64'(n <= 3 && !aligned), 64'(1));
    repeat (6) @(negedge clk);
    #1 drop_active = 1'b0;
    wait_done(target, 2000);

    // Reset pulse while checking lanes.
    @(negedge clk);
    #1;
    w[1] = 2;
    set_lanes(w, '0, 1'b1, 10);
    pulse_start();
    n = 0;
    while (pll_areset && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    check("busy_before_reset", 64'(busy), 64'(1));
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_after_reset_busy", 64'(busy), 64'(0));
    check("idle_after_reset_pll_areset", 64'(pll_areset), 64'(1));

    // Recovery from reset with a fresh sequence.
    for (int i = 0; i < NL; i++) w[i] = int'($urandom_range(7, 0));
    run(w, '0, 1'b1, 30, 1'b0, 3000);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
